// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian window frame sequencer.
// - Default frame geometry and kernel radius.
// - FSM state encoding for gauss_window_ctrl.
// - Helper to size the output (interior-window) image.
package gauss_pkg;

  localparam int unsigned DEF_WIDTH    = 512;
  localparam int unsigned DEF_HEIGHT   = 512;
  localparam int unsigned DEF_R_KERNEL = 2;

  localparam int unsigned DEF_OUT_W    = DEF_WIDTH  - 2 * DEF_R_KERNEL;
  localparam int unsigned DEF_OUT_H    = DEF_HEIGHT - 2 * DEF_R_KERNEL;
  localparam int unsigned DEF_OUT_SIZE = DEF_OUT_W * DEF_OUT_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of interior windows produced per frame.
  function automatic int unsigned out_size(input int unsigned w,
                                           input int unsigned h,
                                           input int unsigned r);
    return (w - 2 * r) * (h - 2 * r);
  endfunction

endpackage

// File: rtl/gauss_window_ctrl_raster_counter.sv
// Raster position counter (column fast, row slow).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - synchronous clear to (0,0)
//   en        - advance one pixel
//   col, row  - current raster position
//   last      - position is the final pixel of the frame
module raster_counter #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned CW     = 9,
  parameter int unsigned RW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_MAX);
  assign row_end = (row == ROW_MAX);
  assign last    = col_end & row_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        // Row also wraps after the last pixel so it never exceeds HEIGHT-1.
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gauss_window_ctrl.sv
// Frame sequencer for the 5x5 Gaussian window line buffer (buf_to_gauss).
// Accepts a raster pixel stream, forwards it to the buffer, tracks raster
// position and flags cycles on which the buffer window is a valid interior
// window.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - begin a frame (honoured in IDLE only)
//   stall        - downstream hold, forces in_ready low
//   in_valid     - source pixel valid
//   in_pix       - source pixel
//   in_ready     - pixel accepted when in_valid & in_ready
//   buf_write    - write strobe to the line buffer
//   buf_pix      - pixel to the line buffer
//   win_valid    - interior window valid (one cycle after the accept)
//   win_x, win_y - window centre in output-image coordinates
//   busy         - high in RUN and DONE
//   frame_done   - pulse coincident with the final win_valid
module gauss_window_ctrl
  import gauss_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned HEIGHT   = DEF_HEIGHT,
  parameter int unsigned R_KERNEL = DEF_R_KERNEL,
  localparam int unsigned CW      = $clog2(WIDTH),
  localparam int unsigned RW      = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  input  logic          in_valid,
  input  logic [7:0]    in_pix,
  output logic          in_ready,
  output logic          buf_write,
  output logic [7:0]    buf_pix,
  output logic          win_valid,
  output logic [CW-1:0] win_x,
  output logic [RW-1:0] win_y,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned OUT_SIZE = out_size(WIDTH, HEIGHT, R_KERNEL);
  localparam int unsigned OCW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [CW-1:0]  COL_OFF  = CW'(2 * R_KERNEL);
  localparam logic [RW-1:0]  ROW_OFF  = RW'(2 * R_KERNEL);
  localparam logic [OCW-1:0] CNT_LAST = OCW'(OUT_SIZE - 1);

  state_t state;
  state_t state_next;

  logic          accept;
  logic          frame_clr;
  logic          last_pix;
  logic          interior;
  logic          win_gen;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [OCW-1:0] win_cnt;

  assign in_ready  = (state == RUN) & ~stall;
  assign accept    = in_valid & in_ready;
  assign buf_write = accept;
  assign buf_pix   = in_pix;
  assign busy      = (state != IDLE);
  assign frame_clr = (state == IDLE) & start;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CW    (CW),
    .RW    (RW)
  ) u_raster (
    .clk (clk),
    .rst (rst),
    .clr (frame_clr),
    .en  (accept),
    .col (col),
    .row (row),
    .last(last_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_pix) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction below is only used when the compare holds, so no underflow.
  assign interior = (col >= COL_OFF) & (row >= ROW_OFF);
  assign win_gen  = accept & interior;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
      win_cnt    <= '0;
    end else begin
      win_valid  <= win_gen;
      // win_cnt counts windows already issued, so the registered pulse
      // lines up with the final win_valid.
      frame_done <= win_gen & (win_cnt == CNT_LAST);
      if (win_gen) begin
        win_x   <= col - COL_OFF;
        win_y   <= row - ROW_OFF;
        win_cnt <= (win_cnt == CNT_LAST) ? '0 : win_cnt + 1'b1;
      end else if (frame_clr) begin
        win_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Self-checking bench for gauss_window_ctrl on an 8x8 frame, radius 2.
module tb_gauss_window_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned R  = 2;
  localparam int unsigned OW = W - 2 * R;
  localparam int unsigned OH = H - 2 * R;
  localparam int unsigned OS = OW * OH;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst, start, stall, in_valid;
  logic [7:0]    in_pix;
  logic          in_ready, buf_write, win_valid, busy, frame_done;
  logic [7:0]    buf_pix;
  logic [CW-1:0] win_x;
  logic [RW-1:0] win_y;

  typedef struct packed {
    logic          in_ready;
    logic          buf_write;
    logic [7:0]    buf_pix;
    logic          win_valid;
    logic [CW-1:0] win_x;
    logic [RW-1:0] win_y;
    logic          busy;
    logic          frame_done;
  } outs_t;

  outs_t obs, exp_o;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: 0=idle 1=run 2=done, k = pixels accepted this frame.
  int   m_state = 0;
  int   m_k     = 0;
  int   m_nwin  = 0;
  logic m_wv    = 1'b0;
  logic m_fd    = 1'b0;
  int   m_wx    = 0;
  int   m_wy    = 0;

  gauss_window_ctrl #(.WIDTH(W), .HEIGHT(H), .R_KERNEL(R)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .in_valid(in_valid), .in_pix(in_pix), .in_ready(in_ready),
    .buf_write(buf_write), .buf_pix(buf_pix), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle, capture DUT/model outputs at the falling edge,
  // then advance the model across the rising edge.
  task automatic tick(input logic r, input logic st, input logic v, input logic sl);
    logic acc;
    int x, y;
    rst = r; start = st; in_valid = v; stall = sl; in_pix = 8'($urandom);
    @(negedge clk);
    exp_o.in_ready   = (m_state == 1) && !sl;
    exp_o.buf_write  = exp_o.in_ready && v;
    exp_o.buf_pix    = in_pix;
    exp_o.win_valid  = m_wv;
    exp_o.win_x      = CW'(m_wx);
    exp_o.win_y      = RW'(m_wy);
    exp_o.busy       = (m_state != 0);
    exp_o.frame_done = m_fd;
    obs = {in_ready, buf_write, buf_pix, win_valid, win_x, win_y, busy, frame_done};
    acc = exp_o.buf_write;
    if (r) begin
      m_state = 0; m_k = 0; m_nwin = 0; m_wv = 0; m_fd = 0; m_wx = 0; m_wy = 0;
    end else begin
      x = m_k % W;
      y = m_k / W;
      m_wv = 0;
      m_fd = 0;
      if (acc && x >= 2 * R && y >= 2 * R) begin
        m_wv = 1;
        m_wx = x - 2 * R;
        m_wy = y - 2 * R;
        m_nwin++;
        if (m_nwin == OS) begin
          m_fd = 1;
          m_nwin = 0;
        end
      end
      case (m_state)
        0: if (st) begin m_state = 1; m_k = 0; m_nwin = 0; end
        1: if (acc) begin
             if (m_k == W * H - 1) begin m_state = 2; m_k = 0; end
             else m_k++;
           end
        default: m_state = 0;
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; in_valid = 1'b0; in_pix = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // rst together with start: rst wins
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs.busy !== 1'b0 || obs.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b in_ready=%b want 0 0", obs.busy, obs.in_ready);
    end
  endtask

  task automatic test_full_frame();
    int nw = 0, nacc = 0, nfd = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && nfd == 0; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL full_frame cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
      if (obs.win_valid) begin
        if (nw == 0) begin
          n_tests++;
          if (obs.win_x !== 3'd0 || obs.win_y !== 3'd0 || nacc != 4 * W + 5) begin
            n_fail++;
            $display("FAIL first_window got=(%0d,%0d) after %0d accepts want=(0,0) after %0d",
                     obs.win_x, obs.win_y, nacc, 4 * W + 5);
          end
        end
        nw++;
      end
      if (obs.frame_done) begin
        nfd++;
        n_tests++;
        if (obs.win_x !== 3'd3 || obs.win_y !== 3'd3 || !obs.win_valid) begin
          n_fail++;
          $display("FAIL last_window got=(%0d,%0d) wv=%b want=(3,3) wv=1",
                   obs.win_x, obs.win_y, obs.win_valid);
        end
      end
      if (obs.buf_write) nacc++;
    end
    n_tests++;
    if (nw != OS || nfd != 1 || nacc != W * H) begin
      n_fail++;
      $display("FAIL full_frame_counts windows=%0d fd=%0d accepts=%0d want %0d 1 %0d",
               nw, nfd, nacc, OS, W * H);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs.busy !== 1'b0 || obs !== exp_o) begin
      n_fail++;
      $display("FAIL busy_drop got=%h want=%h", obs, exp_o);
    end
  endtask

  task automatic test_random_gaps();
    int nw = 0, nfd = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2000 && nfd == 0; i++) begin
      tick(1'b0, 1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL random_gaps cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
      if (obs.win_valid) begin
        n_tests++;
        if (int'(obs.win_x) != nw % OW || int'(obs.win_y) != nw / OW) begin
          n_fail++;
          $display("FAIL raster_order idx=%0d got=(%0d,%0d) want=(%0d,%0d)",
                   nw, obs.win_x, obs.win_y, nw % OW, nw / OW);
        end
        nw++;
      end
      if (obs.frame_done) nfd++;
    end
    n_tests++;
    if (nw != OS || nfd != 1) begin
      n_fail++;
      $display("FAIL random_gaps_counts windows=%0d fd=%0d want %0d 1", nw, nfd, OS);
    end
  endtask

  task automatic test_start_idle();
    int nfd = 0, nw = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== exp_o || obs.buf_write !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_valid cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
    end
    // start held for the first part of the run
    for (int i = 0; i < 200 && nfd == 0; i++) begin
      tick(1'b0, i < 20, 1'b1, $urandom_range(0, 4) == 0);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL start_held cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
      if (obs.win_valid) nw++;
      if (obs.frame_done) nfd++;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      if (obs.win_valid) nw++;
      if (obs.frame_done) nfd++;
    end
    n_tests++;
    if (nw != OS || nfd != 1 || obs.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_held_counts windows=%0d fd=%0d busy=%b want %0d 1 0",
               nw, nfd, obs.busy, OS);
    end
  endtask

  task automatic test_reset_mid();
    int nacc = 0, nfd = 0, nw = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && nacc < 30; i++) begin
      tick(1'b0, 1'b0, $urandom_range(0, 2) != 0, 1'b0);
      if (obs.buf_write) nacc++;
      if (obs.frame_done) nfd++;
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs !== exp_o) begin
      n_fail++;
      $display("FAIL reset_mid_cycle got=%h want=%h", obs, exp_o);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs !== exp_o || obs.busy || obs.win_valid || obs.frame_done || obs.in_ready
        || obs.win_x !== 3'd0 || obs.win_y !== 3'd0 || nfd != 0) begin
      n_fail++;
      $display("FAIL reset_mid_after got=%h want=%h fd=%0d", obs, exp_o, nfd);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2000 && nfd == 0; i++) begin
      tick(1'b0, 1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL reset_mid_refill cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
      if (obs.win_valid) nw++;
      if (obs.frame_done) nfd++;
    end
    n_tests++;
    if (nw != OS || nfd != 1) begin
      n_fail++;
      $display("FAIL reset_mid_counts windows=%0d fd=%0d want %0d 1", nw, nfd, OS);
    end
  endtask

  task automatic test_back_to_back();
    int nw = 0, nfd = 0;
    logic restart = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && nfd < 2; i++) begin
      // restart is raised in the first IDLE cycle after frame_done
      tick(1'b0, restart, 1'b1, $urandom_range(0, 7) == 0);
      restart = 1'b0;
      n_tests++;
      if (obs !== exp_o) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs, exp_o);
      end
      if (obs.win_valid) nw++;
      if (obs.frame_done) begin
        nfd++;
        restart = (nfd == 1);
      end
    end
    n_tests++;
    if (nw != 2 * OS || nfd != 2) begin
      n_fail++;
      $display("FAIL back_to_back_counts windows=%0d fd=%0d want %0d 2", nw, nfd, 2 * OS);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_random_gaps();
    test_start_idle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
